// File: rtl/fmac_sync_fifo.sv
// Single-clock FIFO with normal or show-ahead read, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module fmac_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4096,
  parameter int PTR       = 12,
  parameter int SHOWAHEAD = 0,
  parameter int AF_LEVEL  = 4064,
  parameter int AE_LEVEL  = 32
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [PTR:0]     usedw,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam bit           FWFT    = (SHOWAHEAD != 0);
  localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AF_W    = (PTR+1)'(AF_LEVEL);
  localparam logic [PTR:0] AE_W    = (PTR+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR:0]     usedw_q, usedw_d;
  logic [WIDTH-1:0] q_q;
  logic             ov_q, ov_d;        // show-ahead: q_q holds a live head word
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_c, empty_c;
  logic             wr_acc, rd_acc, fetch;
  logic [PTR:0]     ram_cnt;

  // Accept/fetch decisions and next-state for pointers, count and flags.
  // In show-ahead mode usedw includes the word parked in q_q, so the RAM
  // itself holds usedw - ov words; a fetch refills q_q whenever it is idle
  // or being popped and the RAM has something older than this edge.
  always_comb begin
    full_c      = (usedw_q == DEPTH_W);
    empty_c     = FWFT ? !ov_q : (usedw_q == '0);
    wr_acc      = wrreq && !full_c;
    rd_acc      = rdreq && !empty_c;
    ram_cnt     = usedw_q - {{PTR{1'b0}}, ov_q};
    fetch       = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    usedw_d     = usedw_q;
    ov_d        = ov_q;
    overflow_d  = overflow_q  | (wrreq && full_c);
    underflow_d = underflow_q | (rdreq && empty_c);

    if (FWFT) begin
      fetch = (ram_cnt != '0) && (!ov_q || rd_acc);
      if (fetch)       ov_d = 1'b1;
      else if (rd_acc) ov_d = 1'b0;
    end else begin
      fetch = rd_acc;
    end

    if (fetch)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase
  end

  // Storage array; not cleared by sclr.
  always_ff @(posedge clock) begin
    if (wr_acc && !sclr) mem[wr_ptr_q] <= data;
  end

  // Control state and registered read port.
  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      q_q         <= '0;
      ov_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      ov_q        <= ov_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (fetch) q_q <= mem[rd_ptr_q];
    end
  end

  assign q            = q_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign usedw        = usedw_q;
  assign almost_full  = (usedw_q >= AF_W);
  assign almost_empty = (usedw_q < AE_W);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fmac_sync_fifo.sv
// Directed bench for fmac_sync_fifo: a normal-read instance (a_*) and a
// show-ahead instance (b_*), both 16 deep with AF=14, AE=3.
module tb_fmac_sync_fifo;

  logic       clk = 1'b0;
  logic       sclr;
  logic       a_wr, a_rd, b_wr, b_rd;
  logic [7:0] a_d, b_d;
  logic [7:0] a_q, b_q;
  logic [4:0] a_u, b_u;
  logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmac_sync_fifo #(.WIDTH(8), .DEPTH(16), .PTR(4), .SHOWAHEAD(0),
                   .AF_LEVEL(14), .AE_LEVEL(3)) u_a (
    .clock(clk), .sclr(sclr), .wrreq(a_wr), .data(a_d), .rdreq(a_rd),
    .q(a_q), .full(a_full), .empty(a_empty), .usedw(a_u),
    .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ov), .underflow(a_un));

  fmac_sync_fifo #(.WIDTH(8), .DEPTH(16), .PTR(4), .SHOWAHEAD(1),
                   .AF_LEVEL(14), .AE_LEVEL(3)) u_b (
    .clock(clk), .sclr(sclr), .wrreq(b_wr), .data(b_d), .rdreq(b_rd),
    .q(b_q), .full(b_full), .empty(b_empty), .usedw(b_u),
    .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ov), .underflow(b_un));

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] eq;
    logic [4:0] eu;
    logic       ef, ee, eaf, eae, eov, eun;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [7:0] d,
                     input logic [7:0] eq, input int eu, input logic eov, input logic eun);
    tv[nv].wr  = wr;
    tv[nv].rd  = rd;
    tv[nv].d   = d;
    tv[nv].eq  = eq;
    tv[nv].eu  = 5'(eu);
    tv[nv].ef  = (eu == 16);
    tv[nv].ee  = (eu == 0);
    tv[nv].eaf = (eu >= 14);
    tv[nv].eae = (eu < 3);
    tv[nv].eov = eov;
    tv[nv].eun = eun;
    nv++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, " a.usedw"}, 32'(a_u), 32'd0);
    chk({tag, " a.empty"}, 32'(a_empty), 32'd1);
    chk({tag, " a.full"},  32'(a_full), 32'd0);
    chk({tag, " a.ae"},    32'(a_ae), 32'd1);
    chk({tag, " a.af"},    32'(a_af), 32'd0);
    chk({tag, " a.q"},     32'(a_q), 32'd0);
    chk({tag, " a.ovf"},   32'(a_ov), 32'd0);
    chk({tag, " a.udf"},   32'(a_un), 32'd0);
  endtask

  task automatic chk_b_reset(input string tag);
    chk({tag, " b.usedw"}, 32'(b_u), 32'd0);
    chk({tag, " b.empty"}, 32'(b_empty), 32'd1);
    chk({tag, " b.q"},     32'(b_q), 32'd0);
    chk({tag, " b.ovf"},   32'(b_ov), 32'd0);
    chk({tag, " b.udf"},   32'(b_un), 32'd0);
  endtask

  initial begin
    logic [7:0] sb[$];
    logic [7:0] exp_q;
    int         cnt;
    logic       w, r;

    sclr = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_d = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_d = '0;

    // Fill 0x00..0x0F, overflow, rd+wr at full, drain, underflow, rd+wr at 5.
    for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 8'(i), 8'h00, i + 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h10, 8'h00, 16, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h11, 8'h00, 15, 1'b1, 1'b0);
    for (int j = 1; j < 16; j++) add(1'b0, 1'b1, 8'h00, 8'(j), 15 - j, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h00, 8'h0F, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 8'(8'h20 + i), 8'h0F, i + 1, 1'b1, 1'b1);
    add(1'b1, 1'b1, 8'h25, 8'h20, 5, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h00, 8'h21, 4, 1'b1, 1'b1);

    tick;
    tick;
    chk_a_reset("por");
    chk_b_reset("por");
    sclr = 1'b0;

    for (int k = 0; k < nv; k++) begin
      a_wr = tv[k].wr; a_rd = tv[k].rd; a_d = tv[k].d;
      tick;
      chk($sformatf("v%0d q", k),     32'(a_q),     32'(tv[k].eq));
      chk($sformatf("v%0d usedw", k), 32'(a_u),     32'(tv[k].eu));
      chk($sformatf("v%0d full", k),  32'(a_full),  32'(tv[k].ef));
      chk($sformatf("v%0d empty", k), 32'(a_empty), 32'(tv[k].ee));
      chk($sformatf("v%0d af", k),    32'(a_af),    32'(tv[k].eaf));
      chk($sformatf("v%0d ae", k),    32'(a_ae),    32'(tv[k].eae));
      chk($sformatf("v%0d ovf", k),   32'(a_ov),    32'(tv[k].eov));
      chk($sformatf("v%0d udf", k),   32'(a_un),    32'(tv[k].eun));
    end

    // sclr for two cycles while traffic is still being requested.
    a_wr = 1'b1; a_rd = 1'b1; a_d = 8'h77;
    sclr = 1'b1;
    tick;
    tick;
    chk_a_reset("sclr");
    sclr = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    tick;
    chk_a_reset("post-sclr");

    // Randomised push/pop with 0 < usedw < 16, crossing the pointer wrap.
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_d = 8'($urandom_range(0, 255));
      sb.push_back(a_d);
      tick;
    end
    a_wr = 1'b0;
    cnt = 8;
    for (int c = 0; c < 3 * 16 * 2; c++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (r && !w && cnt == 1)  r = 1'b0;
      if (w && !r && cnt == 15) w = 1'b0;
      a_wr = w; a_rd = r; a_d = 8'($urandom_range(0, 255));
      exp_q = a_q;
      if (r) exp_q = sb.pop_front();
      if (w) sb.push_back(a_d);
      cnt = cnt + int'(w) - int'(r);
      tick;
      chk($sformatf("wrap%0d q", c),     32'(a_q), 32'(exp_q));
      chk($sformatf("wrap%0d usedw", c), 32'(a_u), 32'(cnt));
      chk($sformatf("wrap%0d flags", c), 32'({a_ov, a_un, a_full, a_empty}), 32'd0);
    end
    a_wr = 1'b0; a_rd = 1'b0;

    // Show-ahead: single word into empty appears one edge later.
    b_wr = 1'b1; b_d = 8'hA5;
    tick;                                   // edge N
    b_wr = 1'b0;
    chk("sa N usedw", 32'(b_u), 32'd1);
    chk("sa N empty", 32'(b_empty), 32'd1);
    tick;                                   // edge N+1
    chk("sa N+1 q",     32'(b_q), 32'hA5);
    chk("sa N+1 empty", 32'(b_empty), 32'd0);
    chk("sa N+1 usedw", 32'(b_u), 32'd1);
    b_rd = 1'b1;
    tick;
    b_rd = 1'b0;
    chk("sa pop empty", 32'(b_empty), 32'd1);
    chk("sa pop usedw", 32'(b_u), 32'd0);
    chk("sa pop udf",   32'(b_un), 32'd0);

    // Show-ahead: next word falls through on the same edge as the pop.
    for (int i = 0; i < 3; i++) begin
      b_wr = 1'b1; b_d = 8'(8'hB0 + i);
      tick;
    end
    b_wr = 1'b0;
    chk("sa burst q0",    32'(b_q), 32'hB0);
    chk("sa burst usedw", 32'(b_u), 32'd3);
    b_rd = 1'b1;
    tick;
    chk("sa pop1 q",     32'(b_q), 32'hB1);
    chk("sa pop1 usedw", 32'(b_u), 32'd2);
    tick;
    chk("sa pop2 q",     32'(b_q), 32'hB2);
    chk("sa pop2 usedw", 32'(b_u), 32'd1);
    tick;
    chk("sa pop3 empty", 32'(b_empty), 32'd1);
    chk("sa pop3 usedw", 32'(b_u), 32'd0);
    chk("sa pop3 udf",   32'(b_un), 32'd0);
    tick;
    b_rd = 1'b0;
    chk("sa udf", 32'(b_un), 32'd1);
    chk("sa udf usedw", 32'(b_u), 32'd0);
    tick;
    chk("sa udf sticky", 32'(b_un), 32'd1);

    sclr = 1'b1;
    tick;
    sclr = 1'b0;
    chk_b_reset("sa sclr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
